dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported 32-word data memory between the pipeline's MEM stage (CPU port) and the memory loader/debug port (LD port). Each cycle it grants the memory to at most one requester and drives the memory command. It routes registered read data back to the port that issued the read, and asserts a stall toward the pipeline when the CPU is denied. CPU has priority, but a starvation counter guarantees the loader a slot after a bounded run of CPU grants.

## Interface
- AW, 5: word-address width (memory depth 2^AW).
- DW, 32: data width.
- MAX_CPU_RUN, 4: consecutive CPU grants tolerated while LD waits; legal range 1..15.

- clock  in  1  single clock, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request, held until granted.
- cpu_we  in  1  1 = store word, 0 = load word.
- cpu_addr  in  AW  word address.
- cpu_wdata  in  DW  store data.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline.
- cpu_rvalid  out  1  load data valid, one cycle after the load grant.
- cpu_rdata  out  DW  load data.
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader request, same semantics as the CPU port.
- ld_gnt  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  DW  loader read data.
- mem_en, mem_we  out  1  memory command strobe and write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; registered, valid one cycle after mem_en & ~mem_we.

## Operation
- Grant logic is combinational on the current requests and registered state. At most one grant is asserted per cycle.
- Grant rule:
  - If ld_req and starve_cnt == MAX_CPU_RUN: grant LD.
  - Else if cpu_req: grant CPU.
  - Else if ld_req: grant LD.
  - Else: no grant.
- The granted port's we/addr/wdata drive mem_*, and mem_en = any grant. With no grant, mem_en = 0, and mem_we, mem_addr and mem_wdata are 0.
- starve_cnt is a 4-bit register:
  - +1 when ld_req & cpu_gnt.
  - Cleared when ld_gnt or ~ld_req.
  - Never exceeds MAX_CPU_RUN.
- Read-owner state rd_owner ∈ {NONE, CPU, LD} is updated every cycle:
  - CPU on a CPU load grant.
  - LD on an LD load grant.
  - NONE otherwise (writes and idle cycles included).
- Read return:
  - When rd_owner == CPU: cpu_rvalid = 1 and cpu_rdata = mem_rdata.
  - When rd_owner == LD: ld_rvalid = 1 and ld_rdata = mem_rdata.
  - The non-owner's rvalid is 0 and its rdata holds its last value.
- Writes complete at the grant edge and produce no response.
- Back-to-back grants to either port are allowed every cycle. A load granted in cycle N returns in N+1 while a new grant is issued in N+1.
- Ordering: a load in cycle N+1 to the address written in cycle N returns the new data. The memory writes at the edge ending cycle N, and the arbiter adds no buffering.

## Timing
- Reset (reset_n low, asynchronous):
  - starve_cnt = 0, rd_owner = NONE.
  - cpu_rvalid = ld_rvalid = 0, cpu_rdata = ld_rdata = 0.
  - cpu_gnt, ld_gnt and mem_en are forced 0 while reset_n is low.
  - cpu_stall = cpu_req during reset.
- Grant latency: 0 cycles (same cycle as the request when it wins).
- Read latency: 1 cycle from grant to rvalid.
- Worst-case LD wait: MAX_CPU_RUN cycles of CPU grants, then LD is granted on the next cycle.
- The CPU may be stalled at most 1 cycle per forced LD grant. After the forced grant starve_cnt clears, so the CPU wins again next cycle if LD keeps requesting.
- Reset asserted mid-read (the cycle after a load grant): rvalid is 0 and the return is discarded. No grant is issued until reset_n rises; the first post-reset edge is an ordinary arbitration cycle.
- Requests that drop without a grant are simply withdrawn; no state other than starve_cnt changes.

## Test plan
- CPU only: store 0x000000AB to addr 1, then load addr 1 on the next cycle.
  - cpu_gnt = 1 both cycles, cpu_stall = 0.
  - cpu_rvalid = 1 with 0x000000AB one cycle after the load grant.
- Contention: cpu_req and ld_req held high for 10 cycles, MAX_CPU_RUN = 4.
  - Grant pattern CPU ×4, LD, CPU ×4, LD.
  - cpu_stall = 1 exactly on the LD cycles.
- Both ports load back-to-back: CPU loads addr 2 (0x00003C00) in cycle N, LD loads addr 3 (0x00000001) in cycle N+1.
  - cpu_rvalid only in N+1 with 0x00003C00.
  - ld_rvalid only in N+2 with 0x00000001.
- LD alone while the CPU is idle: ld_gnt is asserted in the request cycle, and starve_cnt stays 0.
- Reset mid-operation: CPU load granted, reset_n pulled low in the return cycle.
  - cpu_rvalid = 0 and all outputs at reset values.
  - After release, the CPU load re-arbitrates and returns correct data.
- Ld_req dropped after 3 starved cycles, then re-raised: the counter restarts from 0, so LD is granted only after 4 further CPU grants.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU (MEM stage) and the loader port.
// Grants in the same cycle as the request, returns load data one cycle later, and stalls the CPU when it loses.
module dmem_arbiter #(
    parameter int AW          = 5,
    parameter int DW          = 32,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } rd_owner_t;

    localparam logic [3:0] L_MAX_RUN = 4'(MAX_CPU_RUN);

    logic [3:0]    r_starve_cnt;
    rd_owner_t     r_rd_owner;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ld_rdata;

    logic w_ld_force;
    logic w_cpu_gnt;
    logic w_ld_gnt;

    // Grants are gated by reset_n so nothing reaches the memory while in reset.
    assign w_ld_force = ld_req && (r_starve_cnt == L_MAX_RUN);
    assign w_cpu_gnt  = reset_n && cpu_req && !w_ld_force;
    assign w_ld_gnt   = reset_n && ld_req && (w_ld_force || !cpu_req);

    assign cpu_gnt   = w_cpu_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign cpu_stall = cpu_req && !w_cpu_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_ld_gnt || !ld_req) begin
            r_starve_cnt <= 4'd0;
        end else if (w_cpu_gnt && (r_starve_cnt < L_MAX_RUN)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_owner <= OWN_NONE;
        end else if (w_cpu_gnt && !cpu_we) begin
            r_rd_owner <= OWN_CPU;
        end else if (w_ld_gnt && !ld_we) begin
            r_rd_owner <= OWN_LD;
        end else begin
            r_rd_owner <= OWN_NONE;
        end
    end

    // Each port keeps showing its last returned word while the other port owns the read bus.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
        end else begin
            if (r_rd_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
            if (r_rd_owner == OWN_LD)  r_ld_rdata  <= mem_rdata;
        end
    end

    assign cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign ld_rvalid  = (r_rd_owner == OWN_LD);
    assign cpu_rdata  = (r_rd_owner == OWN_CPU) ? mem_rdata : r_cpu_rdata;
    assign ld_rdata   = (r_rd_owner == OWN_LD)  ? mem_rdata : r_ld_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int MAXR = 4;

    logic          clock;
    logic          reset_n;
    logic          cpu_req, cpu_we, ld_req, ld_we;
    logic [AW-1:0] cpu_addr, ld_addr;
    logic [DW-1:0] cpu_wdata, ld_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid;
    logic [DW-1:0] cpu_rdata, ld_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_CPU_RUN(MAXR)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port RAM with registered read data.
    logic [DW-1:0] mem_arr [32];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: memory contents, pending returns, loader wait count.
    logic [DW-1:0] ref_mem [32];
    int            m_starve;
    bit            m_cpu_rv, m_ld_rv;
    logic [DW-1:0] m_cpu_last, m_ld_last;

    logic obs_cgnt, obs_lgnt, obs_stall, obs_crv, obs_lrv;
    logic [DW-1:0] obs_crd, obs_lrd;

    task automatic model_reset();
        m_starve   = 0;
        m_cpu_rv   = 0;
        m_ld_rv    = 0;
        m_cpu_last = '0;
        m_ld_last  = '0;
    endtask

    task automatic chk_reset_outputs();
        check_eq("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
        check_eq("rst_ld_gnt",     32'(ld_gnt),     32'd0);
        check_eq("rst_mem_en",     32'(mem_en),     32'd0);
        check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("rst_ld_rvalid",  32'(ld_rvalid),  32'd0);
        check_eq("rst_cpu_rdata",  cpu_rdata,       32'd0);
        check_eq("rst_ld_rdata",   ld_rdata,        32'd0);
        check_eq("rst_cpu_stall",  32'(cpu_stall),  32'(cpu_req));
    endtask

    // One arbitration cycle: drive at posedge+1, check at negedge, advance model, end at next posedge+1.
    task automatic step(input bit c_req, input bit c_we, input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                        input bit l_req, input bit l_we, input logic [AW-1:0] l_addr, input logic [DW-1:0] l_wd);
        int win;
        bit e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        ld_req  = l_req; ld_we  = l_we; ld_addr  = l_addr; ld_wdata  = l_wd;
        #4;
        if (l_req && m_starve == MAXR) win = 2;
        else if (c_req)                win = 1;
        else if (l_req)                win = 2;
        else                           win = 0;
        e_we = 0; e_addr = '0; e_wd = '0;
        if (win == 1) begin e_we = c_we; e_addr = c_addr; e_wd = c_wd; end
        if (win == 2) begin e_we = l_we; e_addr = l_addr; e_wd = l_wd; end
        obs_cgnt = cpu_gnt; obs_lgnt = ld_gnt; obs_stall = cpu_stall;
        obs_crv = cpu_rvalid; obs_lrv = ld_rvalid; obs_crd = cpu_rdata; obs_lrd = ld_rdata;
        check_eq("cpu_gnt",    32'(cpu_gnt),    32'(win == 1));
        check_eq("ld_gnt",     32'(ld_gnt),     32'(win == 2));
        check_eq("cpu_stall",  32'(cpu_stall),  32'(c_req && win != 1));
        check_eq("mem_en",     32'(mem_en),     32'(win != 0));
        check_eq("mem_we",     32'(mem_we),     32'(e_we));
        check_eq("mem_addr",   32'(mem_addr),   32'(e_addr));
        check_eq("mem_wdata",  mem_wdata,       e_wd);
        check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
        check_eq("ld_rvalid",  32'(ld_rvalid),  32'(m_ld_rv));
        check_eq("cpu_rdata",  cpu_rdata,       m_cpu_last);
        check_eq("ld_rdata",   ld_rdata,        m_ld_last);
        m_cpu_rv = (win == 1) && !c_we;
        m_ld_rv  = (win == 2) && !l_we;
        if (m_cpu_rv) m_cpu_last = ref_mem[c_addr];
        if (m_ld_rv)  m_ld_last  = ref_mem[l_addr];
        if (win == 1 && c_we) ref_mem[c_addr] = c_wd;
        if (win == 2 && l_we) ref_mem[l_addr] = l_wd;
        if (win == 2 || !l_req) m_starve = 0;
        else if (win == 1)      m_starve++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        bit exp_ld;
        for (int i = 0; i < 32; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        mem_rdata = '0;
        model_reset();
        reset_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1; cpu_wdata = '0;
        ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0;   ld_wdata  = '0;
        #3;
        chk_reset_outputs();
        check_eq("rst_starve_cnt", 32'(dut.r_starve_cnt), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // CPU store then load of the same word.
        step(1, 1, 5'd1, 32'h0000_00AB, 0, 0, '0, '0);
        check_eq("cpu_only_st_gnt",   32'(obs_cgnt),  32'd1);
        check_eq("cpu_only_st_stall", 32'(obs_stall), 32'd0);
        step(1, 0, 5'd1, '0, 0, 0, '0, '0);
        check_eq("cpu_only_ld_gnt",   32'(obs_cgnt),  32'd1);
        check_eq("cpu_only_ld_stall", 32'(obs_stall), 32'd0);
        idle();
        check_eq("cpu_only_rvalid", 32'(obs_crv), 32'd1);
        check_eq("cpu_only_rdata",  obs_crd,      32'h0000_00AB);

        // Loader alone writes two words.
        step(0, 0, '0, '0, 1, 1, 5'd2, 32'h0000_3C00);
        check_eq("ld_alone_gnt0", 32'(obs_lgnt), 32'd1);
        check_eq("ld_alone_starve0", 32'(dut.r_starve_cnt), 32'd0);
        step(0, 0, '0, '0, 1, 1, 5'd3, 32'h0000_0001);
        check_eq("ld_alone_gnt1", 32'(obs_lgnt), 32'd1);
        check_eq("ld_alone_starve1", 32'(dut.r_starve_cnt), 32'd0);

        // Back-to-back loads from both ports.
        step(1, 0, 5'd2, '0, 0, 0, '0, '0);
        step(0, 0, '0, '0, 1, 0, 5'd3, '0);
        check_eq("b2b_cpu_rvalid", 32'(obs_crv), 32'd1);
        check_eq("b2b_cpu_rdata",  obs_crd,      32'h0000_3C00);
        check_eq("b2b_ld_rvalid_n1", 32'(obs_lrv), 32'd0);
        idle();
        check_eq("b2b_ld_rvalid", 32'(obs_lrv), 32'd1);
        check_eq("b2b_ld_rdata",  obs_lrd,      32'h0000_0001);
        check_eq("b2b_cpu_rvalid_n2", 32'(obs_crv), 32'd0);

        // Sustained contention: CPU x4, LD, CPU x4, LD.
        idle();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 5'(i), '0, 1, 0, 5'(i + 8), '0);
            exp_ld = (i == 4) || (i == 9);
            check_eq($sformatf("cont_ld_gnt%0d", i),  32'(obs_lgnt),  32'(exp_ld));
            check_eq($sformatf("cont_stall%0d", i),   32'(obs_stall), 32'(exp_ld));
        end

        // Loader withdraws after 3 starved cycles; its wait restarts from zero.
        idle();
        for (int i = 0; i < 3; i++) step(1, 0, 5'd4, '0, 1, 0, 5'd5, '0);
        step(1, 0, 5'd4, '0, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 5'(16 + i), 32'(i * 7 + 1), 1, 0, 5'd6, '0);
            check_eq($sformatf("drop_ld_gnt%0d", i), 32'(obs_lgnt), 32'(i == 4));
        end

        // Reset lands in the return cycle of a CPU load.
        idle();
        step(1, 0, 5'd2, '0, 0, 0, '0, '0);
        reset_n = 1'b0;
        #2;
        chk_reset_outputs();
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1, 0, 5'd2, '0, 0, 0, '0, '0);
        check_eq("post_rst_gnt", 32'(obs_cgnt), 32'd1);
        idle();
        check_eq("post_rst_rvalid", 32'(obs_crv), 32'd1);
        check_eq("post_rst_rdata",  obs_crd,      32'h0000_3C00);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
